// File: rtl/conv_enc_k7.sv
// rtl/conv_enc_k7.sv - rate-1/2 K=7 convolutional encoder with zero-tail frame termination
module conv_enc_k7 #(
  parameter logic [6:0] POLY_A = 7'b1101101,
  parameter logic [6:0] POLY_B = 7'b1001111,
  parameter int         CNT_W  = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             enc_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_code,
  output logic             out_last,
  output logic [CNT_W-1:0] sym_count,
  output logic             busy
);

  typedef enum logic {ST_DATA, ST_TAIL} state_t;

  state_t     state;
  logic [5:0] s;
  logic [2:0] tcnt;
  logic       last_done;
  logic       slot_free;
  logic       accept;
  logic       enc_bit;
  logic       out_hs;
  logic [6:0] w;
  logic [1:0] code;

  assign slot_free = !out_valid || out_ready;
  // Gated by reset and clear so nothing is accepted in a cycle whose state is about to be discarded.
  assign in_ready  = HRESETn && !enc_clr && (state == ST_DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign enc_bit   = (state == ST_DATA) ? in_bit : 1'b0;
  assign w         = {enc_bit, s};
  assign code      = {^(w & POLY_A), ^(w & POLY_B)};
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge HCLK) begin
    if (!HRESETn || enc_clr) begin
      state     <= ST_DATA;
      s         <= '0;
      tcnt      <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
      sym_count <= '0;
      busy      <= 1'b0;
      last_done <= 1'b0;
    end else begin
      if (slot_free) begin
        if (state == ST_DATA) begin
          if (accept) begin
            s         <= w[6:1];
            out_code  <= code;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            if (in_last) begin
              state <= ST_TAIL;
              tcnt  <= '0;
            end
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end else begin
          s         <= w[6:1];
          out_code  <= code;
          out_valid <= 1'b1;
          out_last  <= (tcnt == 3'd5);
          if (tcnt == 3'd5) begin
            state <= ST_DATA;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 3'd1;
          end
        end
      end

      // The count shows the full frame length for one cycle before restarting.
      last_done <= out_hs && out_last;
      if (last_done) begin
        sym_count <= out_hs ? CNT_W'(1) : '0;
      end else if (out_hs && (sym_count != '1)) begin
        sym_count <= sym_count + CNT_W'(1);
      end

      if (accept) begin
        busy <= 1'b1;
      end else if (out_hs && out_last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_enc_k7.sv
// tb/tb_conv_enc_k7.sv - directed self-checking bench for conv_enc_k7
module tb_conv_enc_k7;

  logic        HCLK = 1'b0;
  logic        HRESETn, enc_clr, in_valid, in_bit, in_last, out_ready;
  logic        in_ready, out_valid, out_last, busy;
  logic [1:0]  out_code;
  logic [15:0] sym_count;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] codes[$];
  bit         lasts[$];
  int         tail_nrdy;
  int         cycles;
  logic [1:0] imp [7] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11};

  always #5 HCLK = ~HCLK;

  conv_enc_k7 dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .enc_clr   (enc_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .sym_count (sym_count),
    .busy      (busy)
  );

  // Streams one frame with out_ready high, recording every consumed symbol.
  task automatic run_frame(input int n, input logic [31:0] bits, input int budget);
    int sent;
    bit done;
    sent = 0;
    done = 0;
    tail_nrdy = 0;
    cycles = 0;
    codes.delete();
    lasts.delete();
    out_ready = 1'b1;
    while (!done && cycles < budget) begin
      in_valid = (sent < n);
      in_bit   = (sent < n) ? bits[sent] : 1'b0;
      in_last  = (sent == n - 1);
      #1;
      if (sent == n && !in_ready) tail_nrdy++;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        codes.push_back(out_code);
        lasts.push_back(out_last);
        done = out_last;
      end
      cycles++;
      @(negedge HCLK);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; enc_clr = 1'b0; in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(negedge HCLK);
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_chk++; if (sym_count !== 16'd0) begin n_err++; $display("FAIL reset_sym_count: got %0d expected 0", sym_count); end
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    end
    HRESETn = 1'b1;
    in_valid = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    @(negedge HCLK);
  endtask

  task automatic test_impulse();
    int nl;
    run_frame(1, 32'h1, 40);
    n_chk++; if (cycles != 8) begin n_err++; $display("FAIL impulse_cycles: got %0d expected 8", cycles); end
    n_chk++; if (codes.size() != 7) begin n_err++; $display("FAIL impulse_count: got %0d expected 7", codes.size()); end
    for (int i = 0; i < 7 && i < codes.size(); i++) begin
      n_chk++; if (codes[i] !== imp[i]) begin n_err++; $display("FAIL impulse_code[%0d]: got %b expected %b", i, codes[i], imp[i]); end
    end
    nl = 0;
    foreach (lasts[i]) if (lasts[i]) nl++;
    n_chk++; if (nl != 1 || codes.size() != 7 || lasts[6] !== 1'b1) begin n_err++; $display("FAIL impulse_last: got %0d pulses expected 1 on symbol 7", nl); end
    n_chk++; if (tail_nrdy != 6) begin n_err++; $display("FAIL impulse_tail_ready: got %0d not-ready cycles expected 6", tail_nrdy); end
    n_chk++; if (sym_count !== 16'd7) begin n_err++; $display("FAIL impulse_sym_count: got %0d expected 7", sym_count); end
    @(negedge HCLK);
    n_chk++; if (sym_count !== 16'd0) begin n_err++; $display("FAIL impulse_sym_clear: got %0d expected 0", sym_count); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL impulse_busy: got %b expected 0", busy); end
  endtask

  task automatic test_zero_frame();
    int nl;
    int nz;
    run_frame(20, 32'h0, 80);
    n_chk++; if (cycles != 27) begin n_err++; $display("FAIL zero_cycles: got %0d expected 27", cycles); end
    n_chk++; if (codes.size() != 26) begin n_err++; $display("FAIL zero_count: got %0d expected 26", codes.size()); end
    nz = 0;
    foreach (codes[i]) if (codes[i] !== 2'b00) nz++;
    n_chk++; if (nz != 0) begin n_err++; $display("FAIL zero_codes: got %0d nonzero symbols expected 0", nz); end
    nl = 0;
    foreach (lasts[i]) if (lasts[i]) nl++;
    n_chk++; if (nl != 1 || codes.size() != 26 || lasts[25] !== 1'b1) begin n_err++; $display("FAIL zero_last: got %0d pulses expected 1 on symbol 26", nl); end
    n_chk++; if (tail_nrdy != 6) begin n_err++; $display("FAIL zero_tail_ready: got %0d not-ready cycles expected 6", tail_nrdy); end
    n_chk++; if (sym_count !== 16'd26) begin n_err++; $display("FAIL zero_sym_count: got %0d expected 26", sym_count); end
    @(negedge HCLK);
  endtask

  task automatic test_backpressure();
    int  cyc;
    bit  done;
    int  nl;
    codes.delete();
    lasts.delete();
    cyc = 0;
    done = 0;
    while (!done && cyc < 30) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid  = (cyc == 0);
      in_bit    = 1'b1;
      in_last   = 1'b1;
      #1;
      if (!out_ready) begin
        n_chk++; if (out_valid !== 1'b1 || out_code !== 2'b10) begin n_err++; $display("FAIL bp_hold: got valid=%b code=%b expected valid=1 code=10", out_valid, out_code); end
        n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        codes.push_back(out_code);
        lasts.push_back(out_last);
        done = out_last;
      end
      cyc++;
      @(negedge HCLK);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_chk++; if (codes.size() != 7) begin n_err++; $display("FAIL bp_count: got %0d expected 7", codes.size()); end
    for (int i = 0; i < 7 && i < codes.size(); i++) begin
      n_chk++; if (codes[i] !== imp[i]) begin n_err++; $display("FAIL bp_code[%0d]: got %b expected %b", i, codes[i], imp[i]); end
    end
    nl = 0;
    foreach (lasts[i]) if (lasts[i]) nl++;
    n_chk++; if (nl != 1) begin n_err++; $display("FAIL bp_last: got %0d pulses expected 1", nl); end
    @(negedge HCLK);
  endtask

  task automatic test_back_to_back();
    int sent;
    int cyc;
    int nl;
    codes.delete();
    lasts.delete();
    sent = 0;
    cyc = 0;
    nl = 0;
    out_ready = 1'b1;
    while (nl < 2 && cyc < 60) begin
      in_valid = (sent == 0) || (sent == 1 && out_valid && out_last);
      in_bit   = 1'b1;
      in_last  = 1'b1;
      #1;
      if (sent == 1 && out_valid && out_last) begin
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got in_ready=%b expected 1", in_ready); end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        codes.push_back(out_code);
        lasts.push_back(out_last);
        if (out_last) nl++;
      end
      cyc++;
      @(negedge HCLK);
    end
    in_valid = 1'b0;
    n_chk++; if (cyc != 15) begin n_err++; $display("FAIL b2b_cycles: got %0d expected 15", cyc); end
    n_chk++; if (codes.size() != 14) begin n_err++; $display("FAIL b2b_count: got %0d expected 14", codes.size()); end
    for (int i = 0; i < 14 && i < codes.size(); i++) begin
      n_chk++; if (codes[i] !== imp[i % 7] || lasts[i] !== (i % 7 == 6)) begin
        n_err++; $display("FAIL b2b_sym[%0d]: got code=%b last=%b expected code=%b last=%b", i, codes[i], lasts[i], imp[i % 7], (i % 7 == 6));
      end
    end
    n_chk++; if (sym_count !== 16'd7) begin n_err++; $display("FAIL b2b_sym_count: got %0d expected 7", sym_count); end
    @(negedge HCLK);
  endtask

  task automatic test_enc_clr();
    logic [4:0] bits;
    int sent;
    int cyc;
    bits = 5'b01101;
    sent = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (sent < 3 && cyc < 10) begin
      in_valid = 1'b1;
      in_bit   = bits[sent];
      in_last  = 1'b0;
      #1;
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge HCLK);
    end
    in_valid = 1'b0;
    enc_clr = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL clr_pre_valid: got %b expected 1", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clr_in_ready: got %b expected 0", in_ready); end
    @(negedge HCLK);
    enc_clr = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b expected 0", busy); end
    n_chk++; if (sym_count !== 16'd0) begin n_err++; $display("FAIL clr_sym_count: got %0d expected 0", sym_count); end
    run_frame(1, 32'h1, 40);
    n_chk++; if (codes.size() != 7) begin n_err++; $display("FAIL clr_impulse_count: got %0d expected 7", codes.size()); end
    for (int i = 0; i < 7 && i < codes.size(); i++) begin
      n_chk++; if (codes[i] !== imp[i]) begin n_err++; $display("FAIL clr_impulse_code[%0d]: got %b expected %b", i, codes[i], imp[i]); end
    end
    @(negedge HCLK);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_zero_frame();
    test_backpressure();
    test_back_to_back();
    test_enc_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/conv_enc_k7.md
Name: conv_enc_k7

Overview:
- Streaming rate-1/2, constraint-length-7 convolutional encoder for the WiFi PHY transmit path.
- Pairs with the receive-side Viterbi decoder: it uses the same generator polynomials, window bit ordering and code-bit ordering that the decoder's branch metric generator assumes.
- Takes scrambled data bits one per handshake and emits one 2-bit code symbol per input bit.
- At frame end it appends 6 zero tail bits so the trellis terminates in state 0.

Parameters:
- POLY_A, 7'b1101101, generator A; bit 6 multiplies the newest bit.
- POLY_B, 7'b1001111, generator B; same bit ordering as POLY_A.
- CNT_W, 16, width of the frame symbol counter.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  synchronous active-low reset.
- enc_clr  in  1  synchronous clear: aborts the frame and zeroes all state.
- in_valid  in  1  input bit valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- in_bit  in  1  data bit.
- in_last  in  1  marks the final data bit of the frame; sampled with in_bit.
- out_valid  out  1  out_code valid.
- out_ready  in  1  downstream accepts out_code.
- out_code  out  2  [1]=parity A, [0]=parity B.
- out_last  out  1  asserted with the final tail symbol of the frame.
- sym_count  out  CNT_W  symbols emitted in the current frame, saturating.
- busy  out  1  frame in progress: first bit accepted, last tail symbol not yet accepted.

Behaviour:
- Reset (HRESETn=0 at HCLK edge) or enc_clr=1:
  - out_valid=0, out_code=0, out_last=0, sym_count=0, busy=0.
  - Shift register s[5:0]=0, tail counter=0, state=DATA.
  - enc_clr has priority over every other event in the same cycle. Any pending output symbol is discarded.
- Encode window: w[6:0]={b,s[5:0]}.
  - b is the incoming bit, s[5] the previous bit, s[0] the oldest.
  - A = XOR-reduce(w & POLY_A); B = XOR-reduce(w & POLY_B).
  - On each encode, s <= {b,s[5:1]}.
- Output register: one-entry.
  - "Slot free" = !out_valid || out_ready.
  - out_code, out_last and out_valid change only when the slot is free.
  - They are held stable while out_valid=1 and out_ready=0.
- State DATA:
  - in_ready = slot free.
  - Input accept (in_valid && in_ready): encode b=in_bit, load the output register next cycle with out_valid=1, out_last=0. Latency is 1 cycle from accept to out_valid.
  - Accept with in_last=1: go to TAIL with tail counter=0.
  - No accept and slot free: out_valid <= 0.
- State TAIL:
  - in_ready=0.
  - Each cycle the slot is free, encode b=0 and increment the tail counter.
  - On the 6th tail symbol, set out_last=1 and go to DATA. s is then 0 by construction.
  - The first tail symbol is generated in the cycle after the in_last accept, if the slot is free.
- sym_count:
  - Increments on each output handshake (out_valid && out_ready). Saturates at all-ones.
  - Clears to 0 on the cycle after the handshake with out_last=1, and on reset/enc_clr.
- busy:
  - Set on the first input accept of a frame.
  - Cleared on the out_last handshake.
- Back-to-back frames: the next frame's first bit may be accepted in the same cycle as the out_last handshake, because the state is already DATA and the slot is free.
- Single-bit frame (first bit has in_last=1): produces 7 symbols.
- Any N-bit frame produces exactly N+6 symbols, with out_last on the last one only.
- in_last is ignored when in_valid=0. in_bit and in_last are don't-care when in_valid=0.
- Combinational paths:
  - in_ready depends combinationally on out_ready.
  - There is no combinational path from in_valid to out_valid.
- Throughput: one symbol per cycle with out_ready held high.

Test Plan:
- Reset: hold HRESETn=0 two cycles with in_valid=1 -> out_valid=0, in_ready=0 during reset, sym_count=0, busy=0; after release in_ready=1.
- Impulse: single bit 1 with in_last=1, out_ready=1 -> codes 11,10,00,11,11,01,11 on consecutive cycles, out_last only on the 7th, sym_count reaches 7 then 0.
- All-zero frame of 20 bits -> 26 symbols all 00, out_last on the 26th, in_ready=0 for the 6 tail cycles.
- Backpressure: during the impulse frame drop out_ready for 3 cycles on the 2nd symbol -> out_code holds 10, in_ready=0, no symbol lost or duplicated, sequence unchanged.
- Back-to-back: two impulse frames with the second first-bit offered during the out_last cycle -> accepted that cycle, 14 symbols total, two out_last pulses, second frame codes identical to the first.
- enc_clr mid-frame: after 3 of 5 bits, pulse enc_clr with out_valid=1 -> out_valid=0 next cycle, busy=0, s=0; a new impulse frame then yields 11,10,00,11,11,01,11.
